// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit common-anode 7-segment display path.
package fnd_pkg;

  // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}, dp off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int unsigned DP_BIT = 7;

  // Digit positions, rightmost first.
  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  // BCD digit to active-low segment pattern; out-of-range digits are blank.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary (0..99) to two-digit BCD converter by repeated subtract-10.
// One subtraction per clock; done pulses for one cycle with tens/ones valid.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       done
);

  logic       busy_q;
  logic [6:0] rem_q;
  logic [3:0] acc_q;
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic       done_q;

  // Conversion engine: a new start always restarts, even mid-conversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      acc_q  <= '0;
      tens_q <= '0;
      ones_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= bin;
        acc_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (rem_q >= 7'd10) begin
          rem_q <= rem_q - 7'd10;
          acc_q <= acc_q + 4'd1;
        end else begin
          tens_q <= acc_q;
          ones_q <= rem_q[3:0];
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;
  assign done = done_q;

endmodule

// File: rtl/timer_fnd_display.sv
// Cook-timer display end: multiplexed MM.SS on a 4-digit common-anode
// 7-segment display, frame-synchronous time capture, alarm blink and buzzer.
module timer_fnd_display
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 4_000,
  parameter int unsigned BLINK_HZ = 2,
  parameter int unsigned BUZZ_HZ  = 2_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic       alarm,
  output logic [7:0] seg_n,
  output logic [3:0] com_n,
  output logic       buzzer
);

  localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned TONE_DIV  = CLK_HZ / (2 * BUZZ_HZ);
  localparam int unsigned SCAN_W    = $clog2(SCAN_DIV + 1);
  localparam int unsigned BLINK_W   = $clog2(BLINK_DIV + 1);
  localparam int unsigned TONE_W    = $clog2(TONE_DIV + 1);

  // The BCD converter must finish well inside one digit slot.
  if (SCAN_DIV < 16) begin : g_scan_div_check
    $error("timer_fnd_display: CLK_HZ/SCAN_HZ must be >= 16");
  end

  logic [SCAN_W-1:0]  scan_cnt_q;
  logic               tick;
  logic [1:0]         idx_q;
  logic               frame_wrap;
  logic [6:0]         sec_sh_q, min_sh_q;
  logic [6:0]         sec_clamp, min_clamp;
  logic               start_q;
  logic [3:0]         sec_tens, sec_ones, min_tens, min_ones;
  logic               sec_done, min_done;
  logic [3:0]         sec_tens_q, sec_ones_q, min_tens_q, min_ones_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_on_q;
  logic [TONE_W-1:0]  tone_cnt_q;
  logic               tone_q;
  logic [7:0]         seg_d, seg_n_q;
  logic [3:0]         com_d, com_n_q;
  logic               buzzer_q;

  assign tick       = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign frame_wrap = tick && (idx_q == DIG_MIN_TENS);
  assign sec_clamp  = (sec > 8'd59) ? 7'd59 : sec[6:0];
  assign min_clamp  = (min > 8'd99) ? 7'd99 : min[6:0];

  // Scan divider and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      scan_cnt_q <= tick ? '0 : scan_cnt_q + SCAN_W'(1);
      if (tick) idx_q <= idx_q + 2'd1;
    end
  end

  // Frame capture: shadow the clamped time on the 3->0 wrap, start BCD next clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_sh_q <= '0;
      min_sh_q <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= frame_wrap;
      if (frame_wrap) begin
        sec_sh_q <= sec_clamp;
        min_sh_q <= min_clamp;
      end
    end
  end

  bin2bcd_seq u_sec_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_q),
    .bin     (sec_sh_q),
    .tens    (sec_tens),
    .ones    (sec_ones),
    .done    (sec_done)
  );

  bin2bcd_seq u_min_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_q),
    .bin     (min_sh_q),
    .tens    (min_tens),
    .ones    (min_ones),
    .done    (min_done)
  );

  // Displayed digits change only when a conversion completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
    end else begin
      if (sec_done) begin
        sec_tens_q <= sec_tens;
        sec_ones_q <= sec_ones;
      end
      if (min_done) begin
        min_tens_q <= min_tens;
        min_ones_q <= min_ones;
      end
    end
  end

  // Blink phase and buzzer tone dividers run only while alarm is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
    end else if (!alarm) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
    end else begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        phase_on_q  <= ~phase_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
      if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
        tone_cnt_q <= '0;
        tone_q     <= ~tone_q;
      end else begin
        tone_cnt_q <= tone_cnt_q + TONE_W'(1);
      end
    end
  end

  // Segment/common content for the current digit index.
  always_comb begin
    seg_d = SEG_BLANK;
    case (idx_q)
      DIG_SEC_ONES: seg_d = seg_of(sec_ones_q);
      DIG_SEC_TENS: seg_d = seg_of(sec_tens_q);
      DIG_MIN_ONES: begin
        seg_d         = seg_of(min_ones_q);
        seg_d[DP_BIT] = 1'b0;
      end
      DIG_MIN_TENS: seg_d = (min_tens_q == 4'd0) ? SEG_BLANK : seg_of(min_tens_q);
      default:      seg_d = SEG_BLANK;
    endcase
    com_d = phase_on_q ? ~(4'b0001 << idx_q) : 4'hF;
  end

  // Output registers: display updates on tick, buzzer every clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n_q  <= SEG_BLANK;
      com_n_q  <= 4'hF;
      buzzer_q <= 1'b0;
    end else begin
      if (tick) begin
        seg_n_q <= seg_d;
        com_n_q <= com_d;
      end
      buzzer_q <= tone_q & alarm & phase_on_q;
    end
  end

  assign seg_n  = seg_n_q;
  assign com_n  = com_n_q;
  assign buzzer = buzzer_q;

endmodule

// File: tb/tb_timer_fnd_display.sv
// Directed self-checking bench for timer_fnd_display with small dividers:
// tick every 20 clks, blink window 100 clks, tone toggle every 5 clks.
module tb_timer_fnd_display;

  logic       clk;
  logic       reset_n;
  logic [7:0] sec;
  logic [7:0] min;
  logic       alarm;
  logic [7:0] seg_n;
  logic [3:0] com_n;
  logic       buzzer;

  int unsigned errors = 0;
  int unsigned checks = 0;

  timer_fnd_display #(
    .CLK_HZ   (1000),
    .SCAN_HZ  (50),
    .BLINK_HZ (5),
    .BUZZ_HZ  (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sec     (sec),
    .min     (min),
    .alarm   (alarm),
    .seg_n   (seg_n),
    .com_n   (com_n),
    .buzzer  (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for com_n to newly take the target value; sample 1 after posedge.
  task automatic wait_com(input string tag, input logic [3:0] target);
    logic [3:0] prev;
    logic       hit;
    prev = com_n;
    hit  = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (com_n == target && prev != target) hit = 1'b1;
      prev = com_n;
    end
    check_eq({tag, "_wait"}, {31'd0, hit}, 32'd1);
  endtask

  // Read one full frame; result packed {digit3, digit2, digit1, digit0}.
  task automatic read_frame(input string tag, output logic [31:0] f);
    wait_com(tag, 4'b1110); f[7:0]   = seg_n;
    wait_com(tag, 4'b1101); f[15:8]  = seg_n;
    wait_com(tag, 4'b1011); f[23:16] = seg_n;
    wait_com(tag, 4'b0111); f[31:24] = seg_n;
  endtask

  logic [31:0] frame;
  logic        buz  [300];
  logic        comf [300];
  int          n;
  int          cnt;

  initial begin
    reset_n = 1'b1;
    sec     = 8'd0;
    min     = 8'd0;
    alarm   = 1'b0;

    // 1: reset values, first tick 20 clocks after release
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_seg", seg_n, 32'hFF);
    check_eq("rst_com", com_n, 32'hF);
    check_eq("rst_buz", buzzer, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (com_n != 4'hF) n = i;
    end
    check_eq("first_tick_clks", n, 32'd20);
    check_eq("first_tick_com", com_n, 32'he);
    check_eq("first_tick_seg", seg_n, 32'hC0);

    // 2: 3:27, capture at next wrap, then two consistent frames
    min = 8'd3;
    sec = 8'd27;
    wait_com("t2_cap", 4'b0111);
    read_frame("t2_f1", frame);
    check_eq("t2_frame1", frame, 32'hFF30A4F8);
    read_frame("t2_f2", frame);
    check_eq("t2_frame2", frame, 32'hFF30A4F8);
    check_eq("t2_buz", buzzer, 32'd0);

    // 3: change seconds mid-frame, old digits held until next capture
    wait_com("t3", 4'b1110);
    check_eq("t3_d0_old", seg_n, 32'hF8);
    sec = 8'd28;
    wait_com("t3", 4'b1101);
    check_eq("t3_d1", seg_n, 32'hA4);
    wait_com("t3", 4'b1011);
    check_eq("t3_d2", seg_n, 32'h30);
    wait_com("t3", 4'b0111);
    check_eq("t3_d3", seg_n, 32'hFF);
    read_frame("t3_f", frame);
    check_eq("t3_frame_new", frame, 32'hFF30A480);

    // 4: clamp 120:75 -> 99:59
    min = 8'd120;
    sec = 8'd75;
    wait_com("t4_cap", 4'b0111);
    read_frame("t4_f", frame);
    check_eq("t4_clamp", frame, 32'h90109290);

    // 5: alarm blink and buzzer, sample k after the k-th edge following assertion
    min   = 8'd0;
    sec   = 8'd0;
    alarm = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      buz[k]  = buzzer;
      comf[k] = (com_n == 4'hF);
    end
    check_eq("t5_buz4", buz[4], 32'd0);
    check_eq("t5_buz5", buz[5], 32'd1);
    check_eq("t5_buz9", buz[9], 32'd1);
    check_eq("t5_buz10", buz[10], 32'd0);
    cnt = 0; for (int k = 0; k < 100; k++) cnt += int'(buz[k]);
    check_eq("t5_buz_on1", cnt, 32'd50);
    cnt = 0; for (int k = 100; k < 200; k++) cnt += int'(buz[k]);
    check_eq("t5_buz_off", cnt, 32'd0);
    cnt = 0; for (int k = 200; k < 300; k++) cnt += int'(buz[k]);
    check_eq("t5_buz_on2", cnt, 32'd50);
    cnt = 0; for (int k = 20; k < 100; k++) cnt += int'(comf[k]);
    check_eq("t5_com_on1_blank", cnt, 32'd0);
    cnt = 0; for (int k = 120; k < 200; k++) cnt += int'(!comf[k]);
    check_eq("t5_com_off_lit", cnt, 32'd0);
    cnt = 0; for (int k = 220; k < 300; k++) cnt += int'(comf[k]);
    check_eq("t5_com_on2_blank", cnt, 32'd0);
    check_eq("t5_buz299", buz[299], 32'd1);
    alarm = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_buz_drop", buzzer, 32'd0);
    n = 0;
    for (int i = 1; i <= 25 && n == 0; i++) begin
      @(posedge clk); #1;
      if (com_n != 4'hF) n = i;
    end
    check_eq("t5_restore", {31'd0, n != 0}, 32'd1);
    read_frame("t5_f", frame);
    check_eq("t5_frame_000", frame, 32'hFF40C0C0);

    // 6: async reset while index=2, restart at index 0, fresh capture
    min = 8'd12;
    sec = 8'd34;
    wait_com("t6", 4'b1101);
    #3 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_seg", seg_n, 32'hFF);
    check_eq("t6_rst_com", com_n, 32'hF);
    check_eq("t6_rst_buz", buzzer, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (com_n != 4'hF) n = i;
    end
    check_eq("t6_tick_clks", n, 32'd20);
    check_eq("t6_tick_com", com_n, 32'he);
    check_eq("t6_d0_reset", seg_n, 32'hC0);
    wait_com("t6", 4'b1101);
    check_eq("t6_d1_reset", seg_n, 32'hC0);
    wait_com("t6", 4'b1011);
    check_eq("t6_d2_reset", seg_n, 32'h40);
    wait_com("t6", 4'b0111);
    check_eq("t6_d3_reset", seg_n, 32'hFF);
    read_frame("t6_f", frame);
    check_eq("t6_frame_new", frame, 32'hF924B099);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
